// File: rtl/mem_stage_pkg.sv
// Shared bus widths and field layouts for the memory stage.
// Used by execute, memory and write-back stage logic.
package mem_stage_pkg;

    localparam int ES_TO_MS_BUS_WD = 87;
    localparam int MS_TO_WS_BUS_WD = 70;
    localparam int MS_FORWARD_WD   = 72;

    typedef enum logic [1:0] {
        MS_IDLE = 2'd0,
        MS_WAIT = 2'd1,
        MS_HOLD = 2'd2
    } ms_state_e;

    typedef struct packed {
        logic [3:0]  mul_div_op;
        logic        mul_div_sign;
        logic [1:0]  addr_lo;
        logic        mem_we;
        logic        ld_w;
        logic        ld_b;
        logic        ld_bu;
        logic        ld_h;
        logic        ld_hu;
        logic        st_w;
        logic        st_b;
        logic        st_h;
        logic        res_from_mem;
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] alu_result;
        logic [31:0] pc;
    } es_to_ms_t;

    typedef struct packed {
        logic        gr_we;
        logic [4:0]  dest;
        logic [31:0] final_result;
        logic [31:0] pc;
    } ms_to_ws_t;

    typedef struct packed {
        logic        data_pending;
        logic [31:0] pc;
        logic [31:0] final_result;
        logic [4:0]  dest;
        logic        gr_we;
        logic        valid;
    } ms_forward_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data alignment: picks the addressed byte/half of the
// returned word and sign- or zero-extends it.
module load_align (
    input  logic [31:0] w,
    input  logic [1:0]  addr_lo,
    input  logic        ld_w,
    input  logic        ld_b,
    input  logic        ld_bu,
    input  logic        ld_h,
    input  logic        ld_hu,
    output logic [31:0] value
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = w[7:0];
        unique case (addr_lo)
            2'd0: byte_sel = w[7:0];
            2'd1: byte_sel = w[15:8];
            2'd2: byte_sel = w[23:16];
            2'd3: byte_sel = w[31:24];
            default: byte_sel = w[7:0];
        endcase
    end

    assign half_sel = addr_lo[1] ? w[31:16] : w[15:0];

    always_comb begin
        value = w;
        unique case (1'b1)
            ld_w:  value = w;
            ld_b:  value = {{24{byte_sel[7]}}, byte_sel};
            ld_bu: value = {24'd0, byte_sel};
            ld_h:  value = {{16{half_sel[15]}}, half_sel};
            ld_hu: value = {16'd0, half_sel};
            default: value = w;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: waits for the data-SRAM response, aligns loads,
// picks the mul/div result and hands one bundle to write-back.
module mem_stage
    import mem_stage_pkg::*;
(
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_allowin,
    input  logic                       ws_allowin,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    output logic [MS_FORWARD_WD-1:0]   ms_forward,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       data_sram_data_ok,
    input  logic [63:0]                mul_result,
    input  logic [31:0]                div_quotient,
    input  logic [31:0]                div_remainder
);

    es_to_ms_t   es_bus;
    es_to_ms_t   ms_bus;
    ms_state_e   state;
    ms_state_e   state_nxt;
    logic        ms_valid;
    logic [31:0] rdata_buf;
    logic        ready_go;
    logic        capture;
    logic        data_pending;
    logic        accept;
    logic        in_mem_op;
    logic [31:0] ld_value;
    logic [31:0] final_result;
    ms_to_ws_t   ws_out;
    ms_forward_t fwd_out;

    assign es_bus    = es_to_ms_t'(es_to_ms_bus);
    assign accept    = es_to_ms_valid & ms_allowin;
    assign in_mem_op = es_bus.res_from_mem | es_bus.mem_we;

    assign ms_allowin     = !ms_valid | (ready_go & ws_allowin);
    assign ms_to_ws_valid = ms_valid & ready_go;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= MS_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Any handoff slot re-targets the state to the incoming instruction.
    always_comb begin
        state_nxt = state;
        unique case (state)
            MS_IDLE, MS_HOLD: begin
                if (ms_allowin) begin
                    state_nxt = (accept && in_mem_op) ? MS_WAIT : MS_IDLE;
                end
            end
            MS_WAIT: begin
                if (data_sram_data_ok) begin
                    state_nxt = MS_HOLD;
                end
            end
            default: state_nxt = MS_IDLE;
        endcase
    end

    always_comb begin
        ready_go = 1'b1;
        capture  = 1'b0;
        unique case (state)
            MS_WAIT: begin
                ready_go = 1'b0;
                capture  = data_sram_data_ok;
            end
            default: begin
                ready_go = 1'b1;
                capture  = 1'b0;
            end
        endcase
    end

    assign data_pending = ms_valid & ms_bus.res_from_mem
                        & (state == MS_WAIT);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_valid <= 1'b0;
        end else if (ms_allowin) begin
            ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ms_bus <= '0;
        end else if (accept) begin
            ms_bus <= es_bus;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rdata_buf <= 32'd0;
        end else if (capture) begin
            rdata_buf <= data_sram_rdata;
        end
    end

    load_align u_load_align (
        .w       (rdata_buf),
        .addr_lo (ms_bus.addr_lo),
        .ld_w    (ms_bus.ld_w),
        .ld_b    (ms_bus.ld_b),
        .ld_bu   (ms_bus.ld_bu),
        .ld_h    (ms_bus.ld_h),
        .ld_hu   (ms_bus.ld_hu),
        .value   (ld_value)
    );

    always_comb begin
        if (ms_bus.res_from_mem) begin
            final_result = ld_value;
        end else if (ms_bus.mul_div_op[0]) begin
            final_result = mul_result[31:0];
        end else if (ms_bus.mul_div_op[1]) begin
            final_result = mul_result[63:32];
        end else if (ms_bus.mul_div_op[2]) begin
            final_result = div_quotient;
        end else if (ms_bus.mul_div_op[3]) begin
            final_result = div_remainder;
        end else begin
            final_result = ms_bus.alu_result;
        end
    end

    always_comb begin
        ws_out.gr_we        = ms_bus.gr_we;
        ws_out.dest         = ms_bus.dest;
        ws_out.final_result = final_result;
        ws_out.pc           = ms_bus.pc;
    end

    always_comb begin
        fwd_out.data_pending = data_pending;
        fwd_out.pc           = ms_bus.pc;
        fwd_out.final_result = final_result;
        fwd_out.dest         = ms_bus.dest;
        fwd_out.gr_we        = ms_bus.gr_we;
        fwd_out.valid        = ms_valid;
    end

    assign ms_to_ws_bus = ws_out;
    assign ms_forward   = fwd_out;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed scenarios plus a
// randomized stream checked against a transaction-level model.
module tb_mem_stage;

    logic        clk;
    logic        reset;
    logic        es_to_ms_valid;
    logic [86:0] es_to_ms_bus;
    logic        ms_allowin;
    logic        ws_allowin;
    logic        ms_to_ws_valid;
    logic [69:0] ms_to_ws_bus;
    logic [71:0] ms_forward;
    logic [31:0] data_sram_rdata;
    logic        data_sram_data_ok;
    logic [63:0] mul_result;
    logic [31:0] div_quotient;
    logic [31:0] div_remainder;

    int n_pass;
    int n_total;

    mem_stage dut (
        .clk               (clk),
        .reset             (reset),
        .es_to_ms_valid    (es_to_ms_valid),
        .es_to_ms_bus      (es_to_ms_bus),
        .ms_allowin        (ms_allowin),
        .ws_allowin        (ws_allowin),
        .ms_to_ws_valid    (ms_to_ws_valid),
        .ms_to_ws_bus      (ms_to_ws_bus),
        .ms_forward        (ms_forward),
        .data_sram_rdata   (data_sram_rdata),
        .data_sram_data_ok (data_sram_data_ok),
        .mul_result        (mul_result),
        .div_quotient      (div_quotient),
        .div_remainder     (div_remainder)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [86:0] mk_bus(
        logic [31:0] pc, logic [31:0] alu, logic [4:0] dest,
        logic gr_we, logic rfm, logic [4:0] ldf, logic [2:0] stf,
        logic mem_we, logic [1:0] a, logic [3:0] op);
        return {op, 1'b0, a, mem_we, ldf, stf, rfm, gr_we,
                dest, alu, pc};
    endfunction

    function automatic logic [69:0] mk_exp(logic [86:0] b,
                                           logic [31:0] res);
        return {b[69], b[68:64], res, b[31:0]};
    endfunction

    // Types: 0 alu, 1 ld_w, 2 ld_b, 3 ld_bu, 4 ld_h, 5 ld_hu,
    // 6 st_w, 7 mul_lo, 8 mul_hi, 9 div, 10 mod
    function automatic logic [31:0] ref_final(int t,
        logic [31:0] alu, logic [31:0] w, logic [1:0] a,
        logic [63:0] mul, logic [31:0] q, logic [31:0] r);
        logic [7:0]  b8;
        logic [15:0] h16;
        b8  = 8'(w >> (8 * int'(a)));
        h16 = 16'(w >> (16 * int'(a[1])));
        case (t)
            1: return w;
            2: return 32'($signed(b8));
            3: return 32'(b8);
            4: return 32'($signed(h16));
            5: return 32'(h16);
            7: return mul[31:0];
            8: return mul[63:32];
            9: return q;
            10: return r;
            default: return alu;
        endcase
    endfunction

    function automatic logic [86:0] gen_bus(int t, logic [1:0] a);
        logic [31:0] pc;
        logic [31:0] alu;
        logic [4:0]  d;
        logic [4:0]  ldf;
        logic [3:0]  op;
        pc  = $urandom;
        alu = $urandom;
        d   = 5'($urandom);
        ldf = 5'd0;
        op  = 4'd0;
        case (t)
            1: ldf = 5'b10000;
            2: ldf = 5'b01000;
            3: ldf = 5'b00100;
            4: ldf = 5'b00010;
            5: ldf = 5'b00001;
            7: op = 4'b0001;
            8: op = 4'b0010;
            9: op = 4'b0100;
            10: op = 4'b1000;
            default: ;
        endcase
        if (t == 6) begin
            return mk_bus(pc, alu, d, 1'b0, 1'b0, 5'd0, 3'b100,
                          1'b1, a, 4'd0);
        end
        return mk_bus(pc, alu, d, 1'b1, (t >= 1 && t <= 5),
                      ldf, 3'd0, 1'b0, a, op);
    endfunction

    task automatic idle_inputs();
        es_to_ms_valid    = 1'b0;
        es_to_ms_bus      = '0;
        ws_allowin        = 1'b1;
        data_sram_data_ok = 1'b0;
        data_sram_rdata   = $urandom;
        mul_result        = {$urandom, $urandom};
        div_quotient      = $urandom;
        div_remainder     = $urandom;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        n_total++;
        if (ms_to_ws_valid !== 1'b0)
            $display("FAIL reset_valid got %b want 0", ms_to_ws_valid);
        else n_pass++;
        n_total++;
        if (ms_allowin !== 1'b1)
            $display("FAIL reset_allowin got %b want 1", ms_allowin);
        else n_pass++;
        n_total++;
        if (ms_forward !== 72'd0)
            $display("FAIL reset_fwd got %h want 0", ms_forward);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_alu_stream();
        logic [86:0] b [5];
        logic [69:0] e [5];
        for (int i = 0; i < 5; i++) begin
            b[i] = gen_bus(0, 2'd0);
            e[i] = mk_exp(b[i], b[i][63:32]);
        end
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            idle_inputs();
            es_to_ms_valid = (i < 5);
            es_to_ms_bus   = b[(i < 5) ? i : 0];
            #1;
            n_total++;
            if (ms_allowin !== 1'b1)
                $display("FAIL alu_allowin c%0d got %b want 1",
                         i, ms_allowin);
            else n_pass++;
            if (i >= 1 && i <= 5) begin
                n_total++;
                if (ms_to_ws_valid !== 1'b1 ||
                    ms_to_ws_bus !== e[i-1])
                    $display("FAIL alu_out c%0d got %b/%h want 1/%h",
                             i, ms_to_ws_valid, ms_to_ws_bus, e[i-1]);
                else n_pass++;
            end else if (i == 6) begin
                n_total++;
                if (ms_to_ws_valid !== 1'b0)
                    $display("FAIL alu_drain got %b want 0",
                             ms_to_ws_valid);
                else n_pass++;
            end
        end
    endtask

    task automatic test_ld_b();
        logic [86:0] b;
        int pend;
        b = mk_bus(32'h1c00_0040, 32'h0000_1003, 5'd7, 1'b1, 1'b1,
                   5'b01000, 3'd0, 1'b0, 2'b11, 4'd0);
        pend = 0;
        @(negedge clk);
        idle_inputs();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            idle_inputs();
            if (c == 1) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = 32'h80FF_1234;
            end
            #1;
            if (ms_forward[71]) pend++;
            if (c < 2) begin
                n_total++;
                if (ms_to_ws_valid !== 1'b0)
                    $display("FAIL ldb_early c%0d got %b want 0",
                             c, ms_to_ws_valid);
                else n_pass++;
            end else if (c == 2) begin
                n_total++;
                if (ms_to_ws_valid !== 1'b1 ||
                    ms_to_ws_bus !== mk_exp(b, 32'hFFFF_FF80))
                    $display("FAIL ldb_out got %b/%h want 1/%h",
                             ms_to_ws_valid, ms_to_ws_bus,
                             mk_exp(b, 32'hFFFF_FF80));
                else n_pass++;
            end
        end
        n_total++;
        if (pend != 2)
            $display("FAIL ldb_pending got %0d want 2 cycles", pend);
        else n_pass++;
    endtask

    task automatic test_ld_hu_stall();
        logic [86:0] b;
        logic [69:0] e;
        int seen;
        b = mk_bus(32'h1c00_0080, 32'h0000_2002, 5'd9, 1'b1, 1'b1,
                   5'b00001, 3'd0, 1'b0, 2'b10, 4'd0);
        e = mk_exp(b, 32'h0000_8001);
        seen = 0;
        @(negedge clk);
        idle_inputs();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            idle_inputs();
            ws_allowin = (c >= 3);
            if (c == 0) begin
                data_sram_data_ok = 1'b1;
                data_sram_rdata   = 32'h8001_0000;
            end
            #1;
            if (ms_to_ws_valid && ws_allowin) seen++;
            if (c == 0) begin
                n_total++;
                if (ms_to_ws_valid !== 1'b0)
                    $display("FAIL ldhu_c0 got %b want 0",
                             ms_to_ws_valid);
                else n_pass++;
            end else if (c <= 3) begin
                n_total++;
                if (ms_to_ws_valid !== 1'b1 || ms_to_ws_bus !== e)
                    $display("FAIL ldhu_hold c%0d got %b/%h want 1/%h",
                             c, ms_to_ws_valid, ms_to_ws_bus, e);
                else n_pass++;
            end
            if (c == 1 || c == 2) begin
                n_total++;
                if (ms_allowin !== 1'b0)
                    $display("FAIL ldhu_allowin c%0d got %b want 0",
                             c, ms_allowin);
                else n_pass++;
            end
        end
        n_total++;
        if (seen != 1)
            $display("FAIL ldhu_once got %0d want 1 deliveries", seen);
        else n_pass++;
    endtask

    task automatic test_mul_div();
        logic [86:0] b;
        for (int k = 0; k < 2; k++) begin
            b = mk_bus($urandom, $urandom, 5'd3, 1'b1, 1'b0, 5'd0,
                       3'd0, 1'b0, 2'd0, (k == 0) ? 4'b0010 : 4'b1000);
            @(negedge clk);
            idle_inputs();
            es_to_ms_valid = 1'b1;
            es_to_ms_bus   = b;
            @(negedge clk);
            idle_inputs();
            mul_result    = 64'h0000_0001_0000_0000;
            div_remainder = 32'h7;
            #1;
            n_total++;
            if (ms_to_ws_valid !== 1'b1 ||
                ms_to_ws_bus !== mk_exp(b, (k == 0) ? 32'h1 : 32'h7))
                $display("FAIL muldiv k%0d got %b/%h want 1/%h", k,
                         ms_to_ws_valid, ms_to_ws_bus,
                         mk_exp(b, (k == 0) ? 32'h1 : 32'h7));
            else n_pass++;
        end
        @(negedge clk);
        idle_inputs();
    endtask

    task automatic test_reset_in_wait();
        logic [86:0] b;
        logic [86:0] a;
        b = gen_bus(1, 2'd0);
        a = gen_bus(0, 2'd0);
        @(negedge clk);
        idle_inputs();
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = b;
        @(negedge clk);
        idle_inputs();
        #1;
        n_total++;
        if (ms_forward[71] !== 1'b1)
            $display("FAIL rstw_pending got %b want 1", ms_forward[71]);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        #1;
        n_total++;
        if (ms_to_ws_valid !== 1'b0 || ms_allowin !== 1'b1 ||
            ms_forward !== 72'd0)
            $display("FAIL rstw_clear got %b/%b/%h want 0/1/0",
                     ms_to_ws_valid, ms_allowin, ms_forward);
        else n_pass++;
        @(negedge clk);
        reset = 1'b1;
        data_sram_data_ok = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            idle_inputs();
            #1;
            n_total++;
            if (ms_to_ws_valid !== 1'b0)
                $display("FAIL rstw_late c%0d got %b want 0",
                         c, ms_to_ws_valid);
            else n_pass++;
        end
        @(negedge clk);
        es_to_ms_valid = 1'b1;
        es_to_ms_bus   = a;
        @(negedge clk);
        idle_inputs();
        #1;
        n_total++;
        if (ms_to_ws_valid !== 1'b1 ||
            ms_to_ws_bus !== mk_exp(a, a[63:32]))
            $display("FAIL rstw_add got %b/%h want 1/%h",
                     ms_to_ws_valid, ms_to_ws_bus,
                     mk_exp(a, a[63:32]));
        else n_pass++;
    endtask

    localparam int N = 60;

    task automatic test_random();
        logic [86:0] r_bus [N];
        logic [31:0] r_w   [N];
        logic [63:0] r_mul [N];
        logic [31:0] r_q   [N];
        logic [31:0] r_r   [N];
        int          r_t   [N];
        int          r_k   [N];
        logic [31:0] fin;
        bit occ;
        bit is_mem;
        bit is_ld;
        bit e_valid;
        bit e_allow;
        bit e_pend;
        int idx;
        int age;
        int nxt;
        int done;
        int cyc;
        for (int i = 0; i < N; i++) begin
            r_t[i]   = $urandom_range(0, 10);
            r_k[i]   = $urandom_range(0, 4);
            r_w[i]   = $urandom;
            r_mul[i] = {$urandom, $urandom};
            r_q[i]   = $urandom;
            r_r[i]   = $urandom;
            r_bus[i] = gen_bus(r_t[i], 2'($urandom));
        end
        occ = 0; idx = 0; age = 0; nxt = 0; done = 0; cyc = 0;
        while (done < N && cyc < 3000) begin
            @(negedge clk);
            idle_inputs();
            cyc++;
            ws_allowin = ($urandom_range(0, 3) != 0);
            if (nxt < N && $urandom_range(0, 4) != 0) begin
                es_to_ms_valid = 1'b1;
                es_to_ms_bus   = r_bus[nxt];
            end else begin
                es_to_ms_bus = {$urandom, $urandom, 23'($urandom)};
            end
            is_mem = occ && r_t[idx] >= 1 && r_t[idx] <= 6;
            is_ld  = occ && r_t[idx] >= 1 && r_t[idx] <= 5;
            if (occ) begin
                mul_result    = r_mul[idx];
                div_quotient  = r_q[idx];
                div_remainder = r_r[idx];
                if (is_mem && age == r_k[idx]) begin
                    data_sram_data_ok = 1'b1;
                    data_sram_rdata   = r_w[idx];
                end
            end
            #1;
            e_valid = occ && (!is_mem || age > r_k[idx]);
            e_allow = !occ || (e_valid && ws_allowin);
            e_pend  = is_ld && age <= r_k[idx];
            n_total++;
            if (ms_to_ws_valid !== e_valid || ms_allowin !== e_allow)
                $display("FAIL rnd_hs cyc%0d got %b%b want %b%b", cyc,
                         ms_to_ws_valid, ms_allowin, e_valid, e_allow);
            else n_pass++;
            n_total++;
            if (ms_forward[71] !== e_pend || ms_forward[0] !== occ)
                $display("FAIL rnd_fwd cyc%0d got %b%b want %b%b", cyc,
                         ms_forward[71], ms_forward[0], e_pend, occ);
            else n_pass++;
            if (e_valid) begin
                fin = ref_final(r_t[idx], r_bus[idx][63:32], r_w[idx],
                                r_bus[idx][81:80], r_mul[idx],
                                r_q[idx], r_r[idx]);
                n_total++;
                if (ms_to_ws_bus !== mk_exp(r_bus[idx], fin) ||
                    ms_forward[38:7] !== fin)
                    $display("FAIL rnd_data i%0d t%0d got %h want %h",
                             idx, r_t[idx], ms_to_ws_bus,
                             mk_exp(r_bus[idx], fin));
                else n_pass++;
            end
            if (e_valid && ws_allowin) begin
                done++;
                occ = 0;
            end
            if (es_to_ms_valid && e_allow) begin
                occ = 1;
                idx = nxt;
                nxt++;
                age = 0;
            end else if (occ) begin
                age++;
            end
        end
        n_total++;
        if (done != N)
            $display("FAIL rnd_timeout got %0d want %0d", done, N);
        else n_pass++;
        @(negedge clk);
        idle_inputs();
    endtask

    initial begin
        n_pass  = 0;
        n_total = 0;
        test_reset();
        test_alu_stream();
        test_ld_b();
        test_ld_hu_stall();
        test_mul_div();
        test_reset_in_wait();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
